mem_lsu: RTL
============

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 req_valid  in  1  request present.
REQ-005 req_ready  out  1  block can accept a request.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_size  in  2  00=byte, 01=half, 10=word; 11 treated as word.
REQ-008 req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_rdata  out  32  extended load data; 0 for stores.
REQ-014 rsp_err  out  1  misaligned access flag.
REQ-015 mem_we  out  1  word-memory write enable; write commits on rising edge.
REQ-016 mem_a  out  32  word-memory byte address; bits [1:0] always 00.
REQ-017 mem_wd  out  32  word-memory write data.
REQ-018 mem_rd  in  32  word-memory read data, combinational from mem_a.

Function
REQ-019 FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a transfer occurs on a rising edge with req_valid=1 and req_ready=1, latching all req_* fields.
REQ-021 IDLE transitions on transfer: load -> LOAD; word store -> WRITE; byte/half store -> MERGE; misaligned (with REQ-034) -> RESP with rsp_err=1.
REQ-022 LOAD: mem_a={addr[31:2],2'b00}, mem_we=0; capture the selected byte/half/word of mem_rd (lane = addr[1:0], little-endian), extend per req_unsigned, go to RESP.
REQ-023 MERGE: mem_we=0; read mem_rd, replace the addressed lane(s) with wdata, hold the merged word, go to WRITE.
REQ-024 WRITE: mem_we=1 for exactly one cycle, mem_wd = merged word (sub-word) or wdata (word), go to RESP.
REQ-025 RESP: rsp_valid=1 with rsp_rdata/rsp_err stable; leave for IDLE on the edge where rsp_ready=1; hold otherwise.
REQ-026 Latency from accept edge to first rsp_valid cycle: load 2 edges, word store 2, sub-word store 3, misaligned 1.
REQ-027 mem_we SHALL be 0 in every state except WRITE; mem_a holds the latched word address in LOAD, MERGE and WRITE, and is 0 in IDLE/RESP.
REQ-028 Half access with addr[0]=1 and word access with addr[1:0]!=0 are misaligned; byte accesses are never misaligned.
REQ-029 Requests presented outside IDLE SHALL be ignored (not latched, no memory activity).
REQ-030 No new request is accepted in the cycle rsp_ready completes; the earliest next accept is the following edge.

Reset
REQ-031 reset_n=0 SHALL asynchronously force IDLE, mem_we=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_a=0, mem_wd=0, req_ready=1 after release.
REQ-032 Reset in MERGE or WRITE SHALL abort the transaction; mem_we drops immediately, and no response is produced.
REQ-033 All internal latches (address, data, size, merged word) clear to 0.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN defined: misaligned requests produce no memory access and return rsp_err=1, rsp_rdata=0.
REQ-035 LSU_MISALIGN_TRAP_EN undefined: misalignment is ignored, the lane is taken from the aligned offsets (half uses addr[1], word uses 00), and rsp_err is tied 0.

Verification
REQ-036 Word store 0xDEADBEEF at 0x10, then word load 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 edges after each accept.
REQ-037 Memory word at 0x20 = 0x11223344; byte store 0xAA at 0x22 -> exactly one mem_we pulse, mem_wd=0x11AA3344; subsequent word load returns 0x11AA3344.
REQ-038 Word at 0x30 = 0x8000FF80; signed byte load 0x30 -> 0xFFFFFF80; unsigned byte load 0x30 -> 0x00000080; signed half load 0x32 -> 0xFFFF8000.
REQ-039 With LSU_MISALIGN_TRAP_EN: word store at 0x41 -> rsp_err=1 one edge after accept, mem_we never asserted; without the macro: store writes the word at 0x40.
REQ-040 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; assert reset_n=0 during WRITE -> mem_we falls immediately, the state is IDLE after release, and no rsp_valid is produced.

Source files
------------

// File: rtl/mem_lsu_if.sv
// Bundle of the mem_lsu request, response and word-memory signals.
// The "slave" modport is the LSU itself. The "master" modport is the
// requester together with the word memory that sits behind the LSU.
interface mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output rsp_ready, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  rsp_ready, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: a load/store unit in front of a word-wide memory.
// - Byte and half stores use read-modify-write: MERGE reads the word, then
//   WRITE writes it back.
// - Loads pick the addressed lane and then sign- or zero-extend it.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned requests.
// A trapped request has no memory access and returns rsp_err=1, rsp_rdata=0.
// If the macro is undefined, the low address bits are forced to the natural
// alignment and rsp_err is tied to 0.
module mem_lsu (
    input  logic     clk,
    input  logic     reset_n,
    mem_lsu_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] merged_q;     // store data on accept, merged word after MERGE
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;

    logic        accept;
    logic        req_mis;
    logic [1:0]  lane_off;
    logic [31:0] rd_shift;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept = (state_q == IDLE) && bus.req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
    logic err_q;

    assign req_mis = (bus.req_size == 2'b01) ? bus.req_addr[0] :
                     (bus.req_size[1]        ? (bus.req_addr[1:0] != 2'b00) : 1'b0);
    assign bus.rsp_err = err_q;

    // Error flag, decided at the moment a request is accepted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= req_mis;
        end
    end
`else
    assign req_mis     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    // Lane offset: half accesses ignore addr[0], word accesses ignore both low bits
    always_comb begin
        lane_off = 2'b00;
        case (size_q)
            2'b00:   lane_off = addr_q[1:0];
            2'b01:   lane_off = {addr_q[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
    end

    assign rd_shift = bus.mem_rd >> {lane_off, 3'b000};

    // Extract the addressed lane from the memory word and extend it
    always_comb begin
        load_data = rd_shift;
        case (size_q)
            2'b00:   load_data = unsigned_q ? {24'h0, rd_shift[7:0]}
                                            : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_data = unsigned_q ? {16'h0, rd_shift[15:0]}
                                            : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    // Overlay the store data onto the addressed lane(s) of the memory word
    always_comb begin
        merge_data = bus.mem_rd;
        if (size_q == 2'b00) begin
            merge_data[{lane_off, 3'b000} +: 8] = merged_q[7:0];
        end else if (size_q == 2'b01) begin
            merge_data[{lane_off, 3'b000} +: 16] = merged_q[15:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_mis)              state_d = RESP;
                    else if (!bus.req_we)     state_d = LOAD;
                    else if (bus.req_size[1]) state_d = WRITE;
                    else                      state_d = MERGE;
                end
            end
            LOAD:    state_d = RESP;
            MERGE:   state_d = WRITE;
            WRITE:   state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state. mem_we drops as soon as reset forces IDLE.
    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_we    = (state_q == WRITE);
    assign bus.mem_a     = ((state_q == LOAD) || (state_q == MERGE) || (state_q == WRITE))
                           ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.mem_wd    = (state_q == WRITE) ? merged_q : 32'h0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latches, merged word and load result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= 32'h0;
            merged_q   <= 32'h0;
            rdata_q    <= 32'h0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= bus.req_addr;
                        merged_q   <= bus.req_wdata;
                        rdata_q    <= 32'h0;
                        size_q     <= bus.req_size;
                        unsigned_q <= bus.req_unsigned;
                    end
                end
                LOAD:    rdata_q  <= load_data;
                MERGE:   merged_q <= merge_data;
                default: ;
            endcase
        end
    end
endmodule
